alu_wide_seq: RTL

Multi-cycle sequencer that runs 8*N_BYTES-bit add, subtract and shift operations on the 8-bit combinational ALU, one byte per cycle. It chains the shift/carry bit between bytes through a carry register. It sits directly upstream of the ALU: it drives alu_cmd, the operands and the carry-in, and consumes the result, carry-out, zero and parity.
Towards the core it has a valid/ready request port and a valid/ready response port.

---
 rtl/alu_wide_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_wide_seq.sv
// Byte-serial sequencer for add, subtract and shift on an external 8-bit ALU.
// The carry/shift bit passes from one byte slice to the next through carry_q.
module alu_wide_seq #(
    parameter int N_BYTES = 2,
    localparam int W = 8 * N_BYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic         req_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_rslt,
    output logic         rsp_cout,
    output logic         rsp_zero,
    output logic         rsp_pari,
    output logic [2:0]   alu_cmd,
    output logic [7:0]   alu_inA,
    output logic [7:0]   alu_inB,
    output logic         alu_sc_i,
    input  logic [7:0]   alu_rslt,
    input  logic         alu_sc_o,
    input  logic         alu_zero,
    input  logic         alu_pari
);

    localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BYTES - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_SHL = 3'b001;
    localparam logic [2:0] CMD_SHR = 3'b010;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [N_BYTES-1:0][7:0] a_q, b_q, rslt_q;
    logic [1:0]              op_q;
    logic                    carry_q;
    logic                    zero_acc;
    logic                    par_acc;
    logic [IDX_W-1:0]        idx_q;
    logic                    last_byte;

    // Both ports: a transfer occurs on a rising edge where valid and ready are
    // both high; a producer holds valid and its payload stable until then.
    // SHR walks from the top byte down so the shifted-out bit moves towards bit 0.
    assign last_byte = (op_q == OP_SHR) ? (idx_q == '0) : (idx_q == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_cmd   = CMD_ADD;
        alu_inA   = 8'h00;
        alu_inB   = 8'h00;
        alu_sc_i  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                alu_inA  = a_q[idx_q];
                alu_sc_i = carry_q;
                case (op_q)
                    OP_ADD:  alu_inB = b_q[idx_q];
                    // Subtract as A + ~B + 1; the +1 is the carry preset at accept.
                    OP_SUB:  alu_inB = ~b_q[idx_q];
                    OP_SHL:  alu_cmd = CMD_SHL;
                    default: alu_cmd = CMD_SHR;
                endcase
                if (last_byte) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            rslt_q   <= '0;
            op_q     <= OP_ADD;
            carry_q  <= 1'b0;
            zero_acc <= 1'b1;
            par_acc  <= 1'b0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_q      <= req_a;
                        b_q      <= req_b;
                        op_q     <= req_op;
                        carry_q  <= (req_op == OP_SUB) ? 1'b1 : req_cin;
                        idx_q    <= (req_op == OP_SHR) ? IDX_LAST : '0;
                        zero_acc <= 1'b1;
                        par_acc  <= 1'b0;
                    end
                end
                RUN: begin
                    rslt_q[idx_q] <= alu_rslt;
                    carry_q       <= alu_sc_o;
                    zero_acc      <= zero_acc & alu_zero;
                    par_acc       <= par_acc ^ alu_pari;
                    idx_q         <= (op_q == OP_SHR) ? idx_q - 1'b1 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Flags are only meaningful while a response is offered.
    assign rsp_rslt = rslt_q;
    assign rsp_cout = (state_q == DONE) & carry_q;
    assign rsp_zero = (state_q == DONE) & zero_acc;
    assign rsp_pari = (state_q == DONE) & par_acc;

endmodule
